// File: rtl/riscv_ctrl_pkg.sv
// riscv_ctrl_pkg: opcodes, FSM states, ALU/immediate/mux codes and branch helper for the multicycle control unit
package riscv_ctrl_pkg;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE, S_EXECR, S_EXECI,
        S_ALUWB, S_BRANCH, S_JAL, S_JALR, S_LUI, S_AUIPC, S_MULDIV, S_HALT
    } state_e;

    typedef enum logic [1:0] {ALUOP_ADD, ALUOP_SUB, ALUOP_FUNC} alu_op_e;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_SLT  = 4'd5;
    localparam logic [3:0] ALU_SLTU = 4'd6;
    localparam logic [3:0] ALU_SLL  = 4'd7;
    localparam logic [3:0] ALU_SRL  = 4'd8;
    localparam logic [3:0] ALU_SRA  = 4'd9;

    localparam logic [2:0] IMM_I = 3'd0;
    localparam logic [2:0] IMM_S = 3'd1;
    localparam logic [2:0] IMM_B = 3'd2;
    localparam logic [2:0] IMM_J = 3'd3;
    localparam logic [2:0] IMM_U = 3'd4;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_MDR    = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;
    localparam logic [1:0] RES_IMM    = 2'b11;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    localparam logic [1:0] SRCB_RS2   = 2'b00;
    localparam logic [1:0] SRCB_IMM   = 2'b01;
    localparam logic [1:0] SRCB_4     = 2'b10;

    // Branch condition from rs1-rs2 flags; func3[0] inverts each base condition
    function automatic logic branch_taken(input logic [2:0] f3, input logic z, input logic n,
                                          input logic v, input logic c);
        return f3[2] ? ((f3[1] ? ~c : (n ^ v)) ^ f3[0]) : (z ^ f3[0]);
    endfunction
endpackage

// File: rtl/rv_alu_decoder.sv
// rv_alu_decoder: maps ALUOp/func3/func7/opcode[5] to the encoded ALU operation
module rv_alu_decoder
    import riscv_ctrl_pkg::*;
(
    input  alu_op_e    i_alu_op,
    input  logic [2:0] i_func3,
    input  logic       i_func7,
    input  logic       i_opcode5,
    output logic [3:0] o_alu_ctrl
);
    // SUB only for R-type with IR[30]; shifts right use IR[30] for both R and I forms
    always_comb begin
        o_alu_ctrl = ALU_ADD;
        if (i_alu_op == ALUOP_SUB) o_alu_ctrl = ALU_SUB;
        else if (i_alu_op == ALUOP_FUNC)
            case (i_func3)
                3'b000: o_alu_ctrl = (i_func7 && i_opcode5) ? ALU_SUB : ALU_ADD;
                3'b001: o_alu_ctrl = ALU_SLL;
                3'b010: o_alu_ctrl = ALU_SLT;
                3'b011: o_alu_ctrl = ALU_SLTU;
                3'b100: o_alu_ctrl = ALU_XOR;
                3'b101: o_alu_ctrl = i_func7 ? ALU_SRA : ALU_SRL;
                3'b110: o_alu_ctrl = ALU_OR;
                3'b111: o_alu_ctrl = ALU_AND;
            endcase
    end
endmodule

// File: rtl/riscv_mc_ctrl_unit.sv
// riscv_mc_ctrl_unit: multicycle RV32I Moore control FSM; RV_MEXT_EN enables the MULDIV path
module riscv_mc_ctrl_unit
    import riscv_ctrl_pkg::*;
#(
    parameter int ALU_CTRL_W = 4,
    parameter int IMM_SRC_W  = 3,
    parameter int MEM_WAIT   = 1
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic [6:0]            i_opcode,
    input  logic [2:0]            i_func3,
    input  logic                  i_func7,
    input  logic                  i_func7_0,
    input  logic                  i_zero,
    input  logic                  i_negative,
    input  logic                  i_overflow,
    input  logic                  i_carry,
    input  logic                  i_mem_ready,
    input  logic                  i_md_done,
    output logic                  o_PCWrite,
    output logic                  o_addrSrc,
    output logic                  o_memWrite,
    output logic                  o_IRWrite,
    output logic                  o_regWrite,
    output logic [1:0]            o_resultSrc,
    output logic [1:0]            o_ALUSrcA,
    output logic [1:0]            o_ALUSrcB,
    output logic [ALU_CTRL_W-1:0] o_ALUControl,
    output logic [IMM_SRC_W-1:0]  o_immSrc,
    output logic                  o_md_start,
    output logic                  o_illegal
);
    state_e     r_state, w_next, w_rtype_next;
    logic       r_illegal;
    logic       w_rdy, w_bad_branch, w_md_start, w_md_done;
    logic       w_pc_write, w_addr_src, w_mem_write, w_ir_write, w_reg_write;
    logic [1:0] w_result_src, w_src_a, w_src_b;
    logic [2:0] w_imm_src;
    logic [3:0] w_alu_ctrl;
    alu_op_e    w_alu_op;

    assign w_rdy        = (MEM_WAIT == 0) || i_mem_ready;
    assign w_bad_branch = (i_func3[2:1] == 2'b01);

`ifdef RV_MEXT_EN
    logic r_md_busy;
    // Marks MULDIV cycles after the first so md_start is a single entry pulse
    always_ff @(posedge i_clk)
        r_md_busy <= i_reset ? 1'b0 : (r_state == S_MULDIV) && (w_next == S_MULDIV);
    assign w_md_start   = (r_state == S_MULDIV) && !r_md_busy;
    assign w_md_done    = i_md_done;
    assign w_rtype_next = i_func7_0 ? S_MULDIV : S_EXECR;
`else
    logic w_unused_md_done;
    assign w_unused_md_done = i_md_done;
    assign w_md_start       = 1'b0;
    assign w_md_done        = 1'b0;
    assign w_rtype_next     = i_func7_0 ? S_HALT : S_EXECR;
`endif

    rv_alu_decoder u_alu_dec (
        .i_alu_op  (w_alu_op),
        .i_func3   (i_func3),
        .i_func7   (i_func7),
        .i_opcode5 (i_opcode[5]),
        .o_alu_ctrl(w_alu_ctrl)
    );

    // State register and sticky illegal flag; any entry into HALT is an illegal instruction
    always_ff @(posedge i_clk) begin
        r_state   <= i_reset ? S_FETCH : w_next;
        r_illegal <= i_reset ? 1'b0 : r_illegal || (w_next == S_HALT);
    end

    // Next-state and Moore datapath controls; JALR computes its target then reuses JAL to load PC
    always_comb begin
        w_next       = r_state;
        w_pc_write   = 1'b0;
        w_addr_src   = 1'b0;
        w_mem_write  = 1'b0;
        w_ir_write   = 1'b0;
        w_reg_write  = 1'b0;
        w_result_src = RES_ALUOUT;
        w_src_a      = SRCA_PC;
        w_src_b      = SRCB_RS2;
        w_alu_op     = ALUOP_ADD;
        w_imm_src    = IMM_I;
        case (r_state)
            S_FETCH: begin
                w_src_b      = SRCB_4;
                w_result_src = RES_ALU;
                w_ir_write   = w_rdy;
                w_pc_write   = w_rdy;
                w_next       = w_rdy ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                w_src_a   = SRCA_OLDPC;
                w_src_b   = SRCB_IMM;
                w_imm_src = (i_opcode == OP_JAL) ? IMM_J : IMM_B;
                case (i_opcode)
                    OP_LOAD, OP_STORE: w_next = S_MEMADR;
                    OP_RTYPE:          w_next = w_rtype_next;
                    OP_ITYPE:          w_next = S_EXECI;
                    OP_BRANCH:         w_next = S_BRANCH;
                    OP_JAL:            w_next = S_JAL;
                    OP_JALR:           w_next = S_JALR;
                    OP_LUI:            w_next = S_LUI;
                    OP_AUIPC:          w_next = S_AUIPC;
                    default:           w_next = S_HALT;
                endcase
            end
            S_MEMADR: begin
                w_src_a   = SRCA_RS1;
                w_src_b   = SRCB_IMM;
                w_imm_src = i_opcode[5] ? IMM_S : IMM_I;
                w_next    = i_opcode[5] ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                w_addr_src = 1'b1;
                w_next     = w_rdy ? S_MEMWB : S_MEMREAD;
            end
            S_MEMWB: begin
                w_result_src = RES_MDR;
                w_reg_write  = 1'b1;
                w_next       = S_FETCH;
            end
            S_MEMWRITE: begin
                w_addr_src  = 1'b1;
                w_mem_write = 1'b1;
                w_next      = w_rdy ? S_FETCH : S_MEMWRITE;
            end
            S_EXECR: begin
                w_src_a  = SRCA_RS1;
                w_alu_op = ALUOP_FUNC;
                w_next   = S_ALUWB;
            end
            S_EXECI: begin
                w_src_a  = SRCA_RS1;
                w_src_b  = SRCB_IMM;
                w_alu_op = ALUOP_FUNC;
                w_next   = S_ALUWB;
            end
            S_ALUWB: begin
                w_reg_write = 1'b1;
                w_next      = S_FETCH;
            end
            S_BRANCH: begin
                w_src_a    = SRCA_RS1;
                w_alu_op   = ALUOP_SUB;
                w_pc_write = !w_bad_branch && branch_taken(i_func3, i_zero, i_negative, i_overflow, i_carry);
                w_next     = w_bad_branch ? S_HALT : S_FETCH;
            end
            S_JAL: begin
                w_src_a    = SRCA_OLDPC;
                w_src_b    = SRCB_4;
                w_pc_write = 1'b1;
                w_next     = S_ALUWB;
            end
            S_JALR: begin
                w_src_a = SRCA_RS1;
                w_src_b = SRCB_IMM;
                w_next  = S_JAL;
            end
            S_LUI: begin
                w_result_src = RES_IMM;
                w_imm_src    = IMM_U;
                w_reg_write  = 1'b1;
                w_next       = S_FETCH;
            end
            S_AUIPC: begin
                w_src_a   = SRCA_OLDPC;
                w_src_b   = SRCB_IMM;
                w_imm_src = IMM_U;
                w_next    = S_ALUWB;
            end
            S_MULDIV: w_next = w_md_done ? S_ALUWB : S_MULDIV;
            S_HALT:   w_next = S_HALT;
        endcase
    end

    assign o_PCWrite    = w_pc_write && !i_reset;
    assign o_memWrite   = w_mem_write && !i_reset;
    assign o_IRWrite    = w_ir_write && !i_reset;
    assign o_regWrite   = w_reg_write && !i_reset;
    assign o_md_start   = w_md_start && !i_reset;
    assign o_addrSrc    = w_addr_src;
    assign o_resultSrc  = w_result_src;
    assign o_ALUSrcA    = w_src_a;
    assign o_ALUSrcB    = w_src_b;
    assign o_ALUControl = ALU_CTRL_W'(w_alu_ctrl);
    assign o_immSrc     = IMM_SRC_W'(w_imm_src);
    assign o_illegal    = r_illegal;
endmodule

// File: tb/tb_riscv_mc_ctrl_unit.sv
// tb_riscv_mc_ctrl_unit: randomized instruction-level checking of the multicycle control unit
module tb_riscv_mc_ctrl_unit;
    localparam logic [6:0] LD = 7'b0000011, ST = 7'b0100011, RT = 7'b0110011, IT = 7'b0010011;
    localparam logic [6:0] BR = 7'b1100011, JL = 7'b1101111, JR = 7'b1100111, LU = 7'b0110111, AU = 7'b0010111;
`ifdef RV_MEXT_EN
    localparam bit MEXT = 1'b1;
`else
    localparam bit MEXT = 1'b0;
`endif

    logic       clk = 1'b0, i_reset = 1'b1;
    logic [6:0] i_opcode = '0;
    logic [2:0] i_func3 = '0;
    logic       i_func7 = 0, i_func7_0 = 0, i_zero = 0, i_negative = 0, i_overflow = 0, i_carry = 0;
    logic       i_mem_ready = 1, i_md_done = 0;
    logic       o_PCWrite, o_addrSrc, o_memWrite, o_IRWrite, o_regWrite, o_md_start, o_illegal;
    logic [1:0] o_resultSrc, o_ALUSrcA, o_ALUSrcB;
    logic [3:0] o_ALUControl;
    logic [2:0] o_immSrc;
    int         n_chk = 0, n_fail = 0;

    always #5 clk = ~clk;

    riscv_mc_ctrl_unit dut (
        .i_clk(clk), .i_reset(i_reset), .i_opcode(i_opcode), .i_func3(i_func3), .i_func7(i_func7),
        .i_func7_0(i_func7_0), .i_zero(i_zero), .i_negative(i_negative), .i_overflow(i_overflow),
        .i_carry(i_carry), .i_mem_ready(i_mem_ready), .i_md_done(i_md_done), .o_PCWrite(o_PCWrite),
        .o_addrSrc(o_addrSrc), .o_memWrite(o_memWrite), .o_IRWrite(o_IRWrite), .o_regWrite(o_regWrite),
        .o_resultSrc(o_resultSrc), .o_ALUSrcA(o_ALUSrcA), .o_ALUSrcB(o_ALUSrcB),
        .o_ALUControl(o_ALUControl), .o_immSrc(o_immSrc), .o_md_start(o_md_start), .o_illegal(o_illegal)
    );

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int enables();
        return int'({o_PCWrite, o_memWrite, o_IRWrite, o_regWrite, o_md_start});
    endfunction

    function automatic int alu_ref(input logic [2:0] f3, input logic f7, input bit rtype);
        case (f3)
            3'b000: return (rtype && f7) ? 1 : 0;
            3'b001: return 7;
            3'b010: return 5;
            3'b011: return 6;
            3'b100: return 4;
            3'b101: return f7 ? 9 : 8;
            3'b110: return 3;
            default: return 2;
        endcase
    endfunction

    task automatic do_reset();
        i_reset = 1'b1;
        i_mem_ready = 1'b1;
        i_md_done = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            chk("reset_enables", enables(), 0);
            @(posedge clk); #1;
        end
        i_reset = 1'b0;
        i_md_done = 1'b0;
        chk("reset_illegal", int'(o_illegal), 0);
    endtask

    task automatic exec_instr(input logic [6:0] op, input logic [2:0] f3, input logic f7, input logic f70,
                              input logic [31:0] a, input logic [31:0] b, input int sf, input int sm,
                              input int mdw);
        bit ld, st, r, rr, it, br, md, legal, mem, taken;
        int len, e_pc, e_reg, e_res, e_mem;
        int n_ir, ir_at, n_pc, n_reg, n_mem, n_addr, n_md, res, alu, srca, quiet;
        logic [31:0] d;
        ld = op == LD; st = op == ST; r = op == RT; it = op == IT; br = op == BR;
        rr = r && !f70;
        md = r && f70 && MEXT;
        legal = (ld || st || r || it || br || op == JL || op == JR || op == LU || op == AU)
                && !(br && f3[2:1] == 2'b01) && !(r && f70 && !MEXT);
        mem = legal && (ld || st);
        d = a - b;
        case (f3)
            3'b000: taken = a == b;
            3'b001: taken = a != b;
            3'b100: taken = $signed(a) < $signed(b);
            3'b101: taken = $signed(a) >= $signed(b);
            3'b110: taken = a < b;
            3'b111: taken = a >= b;
            default: taken = 1'b0;
        endcase
        i_opcode = op; i_func3 = f3; i_func7 = f7; i_func7_0 = f70;
        i_zero = d == 0; i_negative = d[31];
        i_overflow = (a[31] ^ b[31]) & (d[31] ^ a[31]); i_carry = a >= b;
        if (!legal) len = sf + (br ? 3 : 2);
        else if (ld || op == JR) len = sf + 5;
        else if (br || op == LU) len = sf + 3;
        else if (md) len = sf + 4 + mdw;
        else len = sf + 4;
        if (mem) len += sm;
        e_pc = 1 + int'(legal && br && taken) + int'(legal && (op == JL || op == JR));
        e_reg = (legal && !st && !br) ? 1 : 0;
        e_res = ld ? 1 : (op == LU) ? 3 : 0;
        e_mem = (legal && st) ? sm + 1 : 0;
        n_ir = 0; ir_at = -1; n_pc = 0; n_reg = 0; n_mem = 0; n_addr = 0; n_md = 0;
        res = -1; alu = -1; srca = -1; quiet = 0;
        for (int k = 0; k < len; k++) begin
            if (k < sf) i_mem_ready = 1'b0;
            else if (k == sf) i_mem_ready = 1'b1;
            else if (mem && k >= sf + 3 && k < sf + 3 + sm) i_mem_ready = 1'b0;
            else if (mem && k == sf + 3 + sm) i_mem_ready = 1'b1;
            else i_mem_ready = 1'($urandom_range(0, 1));
            i_md_done = md ? (k == sf + 2 + mdw) : 1'($urandom_range(0, 1));
            @(negedge clk);
            n_ir += int'(o_IRWrite);
            if (o_IRWrite) ir_at = k;
            n_pc += int'(o_PCWrite);
            n_reg += int'(o_regWrite);
            if (o_regWrite) res = int'(o_resultSrc);
            n_mem += int'(o_memWrite);
            n_addr += int'(o_addrSrc);
            n_md += int'(o_md_start);
            if (k == sf + 2) begin
                alu = int'(o_ALUControl);
                srca = int'(o_ALUSrcA);
            end
            @(posedge clk); #1;
        end
        chk("ir_count", n_ir, 1);
        chk("ir_cycle", ir_at, sf);
        chk("pc_writes", n_pc, e_pc);
        chk("reg_writes", n_reg, e_reg);
        chk("mem_writes", n_mem, e_mem);
        chk("addr_alu_cycles", n_addr, mem ? sm + 1 : 0);
        chk("md_start_pulses", n_md, (legal && md) ? 1 : 0);
        if (legal && e_reg == 1) chk("result_src", res, e_res);
        if (legal && (rr || it || br)) begin
            chk("alu_ctrl", alu, br ? 1 : alu_ref(f3, f7, r));
            chk("srca_rs1", srca, 2);
        end
        chk("illegal_flag", int'(o_illegal), legal ? 0 : 1);
        if (!legal) begin
            for (int k = 0; k < 4; k++) begin
                i_mem_ready = 1'($urandom_range(0, 1));
                i_md_done = 1'($urandom_range(0, 1));
                @(negedge clk);
                quiet += enables();
                @(posedge clk); #1;
            end
            chk("halt_quiet", quiet, 0);
            chk("halt_sticky", int'(o_illegal), 1);
            do_reset();
        end
    endtask

    initial begin
        int rw;
        logic [6:0] op;
        logic [31:0] a, b;
        do_reset();
        exec_instr(LD, 3'b010, 0, 0, 0, 0, 0, 3, 0);
        exec_instr(ST, 3'b010, 0, 0, 0, 0, 1, 2, 0);
        exec_instr(BR, 3'b000, 0, 0, 32'd7, 32'd7, 0, 0, 0);
        exec_instr(BR, 3'b000, 0, 0, 32'd7, 32'd8, 0, 0, 0);
        exec_instr(BR, 3'b110, 0, 0, 32'd1, 32'd2, 0, 0, 0);
        exec_instr(BR, 3'b111, 0, 0, 32'd1, 32'd2, 0, 0, 0);
        exec_instr(RT, 3'b000, 1, 0, 0, 0, 0, 0, 0);
        exec_instr(IT, 3'b000, 1, 0, 0, 0, 0, 0, 0);
        exec_instr(IT, 3'b101, 1, 0, 0, 0, 0, 0, 0);
        exec_instr(JL, 3'b000, 0, 0, 0, 0, 0, 0, 0);
        exec_instr(JR, 3'b000, 0, 0, 0, 0, 0, 0, 0);
        exec_instr(LU, 3'b000, 0, 0, 0, 0, 0, 0, 0);
        exec_instr(AU, 3'b000, 0, 0, 0, 0, 0, 0, 0);
        exec_instr(RT, 3'b000, 0, 1, 0, 0, 0, 0, 5);
        exec_instr(7'b1111111, 3'b000, 0, 0, 0, 0, 0, 0, 0);
        exec_instr(BR, 3'b010, 0, 0, 0, 0, 0, 0, 0);
        i_opcode = LD; i_func3 = 3'b010; i_func7 = 0; i_func7_0 = 0; i_mem_ready = 1'b1; i_md_done = 1'b0;
        rw = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            rw += int'(o_regWrite);
            @(posedge clk); #1;
        end
        i_reset = 1'b1;
        @(negedge clk);
        chk("midop_reset_enables", enables(), 0);
        @(posedge clk); #1;
        i_reset = 1'b0;
        @(negedge clk);
        chk("midop_refetch", int'(o_IRWrite), 1);
        rw += int'(o_regWrite);
        chk("midop_no_regwrite", rw, 0);
        @(posedge clk); #1;
        do_reset();
        for (int n = 0; n < 80; n++) begin
            case ($urandom_range(0, 11))
                0: op = LD;
                1: op = ST;
                2, 9: op = RT;
                3: op = IT;
                4, 11: op = BR;
                5: op = JL;
                6: op = JR;
                7: op = LU;
                8: op = AU;
                default: begin
                    op = 7'($urandom);
                    while (op inside {LD, ST, RT, IT, BR, JL, JR, LU, AU}) op = 7'($urandom);
                end
            endcase
            a = $urandom;
            b = ($urandom_range(0, 3) == 0) ? a : $urandom;
            exec_instr(op, 3'($urandom), 1'($urandom), ($urandom_range(0, 4) == 0),
                       a, b, $urandom_range(0, 2), $urandom_range(0, 3), $urandom_range(0, 4));
        end
        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
